// File: rtl/mips_pkg.sv
// Shared definitions for the reduced 8-register MIPS control path:
// opcode/funct constants, ALU and PC-source codes, and the multi-cycle FSM states.
package mips_pkg;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b100
  } alu_op_t;

  typedef enum logic [1:0] {
    PC_SRC_PLUS4  = 2'b00,
    PC_SRC_BRANCH = 2'b01,
    PC_SRC_JUMP   = 2'b10
  } pc_src_t;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEM,
    ST_WRITEBACK
  } state_t;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Bundle of instruction-memory, data-memory, register-file, ALU and PC control
// signals between the multi-cycle controller and its datapath.
interface mips_multicycle_control_if;
  logic        instr_valid;
  logic [31:0] instruction;
  logic        mem_ready;
  logic        alu_zero;

  logic        instr_req;
  logic [2:0]  read_reg_1;
  logic [2:0]  read_reg_2;
  logic [2:0]  write_reg;
  logic        signal_reg_write;
  logic [2:0]  alu_op;
  logic        alu_src_imm;
  logic [31:0] imm_ext;
  logic        mem_read;
  logic        mem_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        illegal;

  // Controller side
  modport master (
    input  instr_valid, instruction, mem_ready, alu_zero,
    output instr_req, read_reg_1, read_reg_2, write_reg, signal_reg_write,
           alu_op, alu_src_imm, imm_ext, mem_read, mem_write, pc_write,
           pc_src, illegal
  );

  // Datapath / memory side
  modport slave (
    output instr_valid, instruction, mem_ready, alu_zero,
    input  instr_req, read_reg_1, read_reg_2, write_reg, signal_reg_write,
           alu_op, alu_src_imm, imm_ext, mem_read, mem_write, pc_write,
           pc_src, illegal
  );
endinterface

// File: rtl/mips_alu_decoder.sv
// Combinational opcode/funct decoder: selects the ALU operation and flags
// unsupported encodings. Shared with the pipelined control.
module mips_alu_decoder
  import mips_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output alu_op_t    o_alu_op,
  output logic       o_illegal
);

  // Map opcode/funct to an ALU operation; anything unrecognised is illegal
  always_comb begin
    o_alu_op  = ALU_ADD;
    o_illegal = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        case (i_funct)
          FN_ADD:  o_alu_op = ALU_ADD;
          FN_SUB:  o_alu_op = ALU_SUB;
          FN_AND:  o_alu_op = ALU_AND;
          FN_OR:   o_alu_op = ALU_OR;
          FN_SLT:  o_alu_op = ALU_SLT;
          default: o_illegal = 1'b1;
        endcase
      end
      OP_LW, OP_SW, OP_ADDI, OP_J: o_alu_op = ALU_ADD;
      OP_BEQ:                      o_alu_op = ALU_SUB;
      default:                     o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Five-state multi-cycle controller for the reduced 8-register MIPS core.
// Latches one instruction per pass and sequences register-file, ALU,
// data-memory and PC control from the FSM state and the instruction register.
module mips_multicycle_control
  import mips_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  mips_multicycle_control_if.master bus
);

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_ir;
  logic        r_illegal;

  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  alu_op_t     w_dec_alu_op;
  logic        w_dec_illegal;
  logic [2:0]  w_write_reg;
  logic        w_is_lw;
  logic        w_is_sw;
  logic        w_uses_imm;

  assign w_opcode   = r_ir[31:26];
  assign w_funct    = r_ir[5:0];
  assign w_is_lw    = (w_opcode == OP_LW);
  assign w_is_sw    = (w_opcode == OP_SW);
  assign w_uses_imm = w_is_lw || w_is_sw || (w_opcode == OP_ADDI);

  // Only the low 3 bits of each register field address the 8-entry file;
  // the upper field bits and the jump target belong to the datapath.
  logic w_unused_ir_bits;
  assign w_unused_ir_bits = ^{r_ir[25:24], r_ir[20:19]};

  mips_alu_decoder u_alu_decoder (
    .i_opcode  (w_opcode),
    .i_funct   (w_funct),
    .o_alu_op  (w_dec_alu_op),
    .o_illegal (w_dec_illegal)
  );

  // Register addresses and immediate come straight from IR
  assign w_write_reg    = (w_opcode == OP_RTYPE) ? r_ir[13:11] : r_ir[18:16];
  assign bus.read_reg_1 = r_ir[23:21];
  assign bus.read_reg_2 = r_ir[18:16];
  assign bus.write_reg  = w_write_reg;
  assign bus.imm_ext    = {{16{r_ir[15]}}, r_ir[15:0]};
  assign bus.illegal    = r_illegal;

  // State register, instruction register and sticky illegal flag
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      r_state   <= ST_FETCH;
      r_ir      <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_FETCH && bus.instr_valid) begin
        r_ir      <= bus.instruction;
        r_illegal <= 1'b0;
      end else if (r_state == ST_DECODE && w_dec_illegal) begin
        r_illegal <= 1'b1;
      end
    end
  end

  // Next-state and control-output decode from state, IR and handshakes
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned and infers a latch.
    w_next_state         = r_state;
    bus.instr_req        = 1'b0;
    bus.signal_reg_write = 1'b0;
    bus.alu_op           = ALU_ADD;
    bus.alu_src_imm      = 1'b0;
    bus.mem_read         = 1'b0;
    bus.mem_write        = 1'b0;
    bus.pc_write         = 1'b0;
    bus.pc_src           = PC_SRC_PLUS4;

    case (r_state)
      ST_FETCH: begin
        bus.instr_req = 1'b1;
        if (bus.instr_valid) w_next_state = ST_DECODE;
      end
      ST_DECODE: begin
        if (w_dec_illegal) begin
          bus.pc_write = 1'b1;
          w_next_state = ST_FETCH;
        end else if (w_opcode == OP_J) begin
          bus.pc_write = 1'b1;
          bus.pc_src   = PC_SRC_JUMP;
          w_next_state = ST_FETCH;
        end else begin
          w_next_state = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        bus.alu_op      = w_dec_alu_op;
        bus.alu_src_imm = w_uses_imm;
        if (w_opcode == OP_BEQ) begin
          bus.pc_write = 1'b1;
          bus.pc_src   = bus.alu_zero ? PC_SRC_BRANCH : PC_SRC_PLUS4;
          w_next_state = ST_FETCH;
        end else if (w_is_lw || w_is_sw) begin
          w_next_state = ST_MEM;
        end else begin
          w_next_state = ST_WRITEBACK;
        end
      end
      ST_MEM: begin
        bus.mem_read  = w_is_lw;
        bus.mem_write = !w_is_lw;
        if (bus.mem_ready) begin
          if (w_is_lw) begin
            w_next_state = ST_WRITEBACK;
          end else begin
            bus.pc_write = 1'b1;
            w_next_state = ST_FETCH;
          end
        end
      end
      ST_WRITEBACK: begin
        bus.signal_reg_write = (w_write_reg != 3'b000);
        bus.pc_write         = 1'b1;
        w_next_state         = ST_FETCH;
      end
      default: w_next_state = ST_FETCH;
    endcase

    // A reset cycle must not commit anything, even from WRITEBACK or MEM
    if (reset) begin
      bus.signal_reg_write = 1'b0;
      bus.mem_read         = 1'b0;
      bus.mem_write        = 1'b0;
      bus.pc_write         = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed-vector bench for mips_multicycle_control: runs one instruction at a
// time, records per-cycle controls (cycle 1 = FETCH entry) and compares them
// with hand-computed expectations.
module tb_mips_multicycle_control;

  localparam int MAX = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_multicycle_control_if bus ();

  mips_multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int n_cycles;

  // Bit k of each packed record holds the value seen in cycle k
  logic [MAX:1] rec_pcw, rec_regw, rec_mrd, rec_mwr, rec_req, rec_imm_sel, rec_ill;
  logic [1:0]   rec_pc_src [1:MAX];
  logic [2:0]   rec_alu_op [1:MAX];
  logic [2:0]   rec_wr     [1:MAX];
  logic [2:0]   rec_rr1    [1:MAX];
  logic [2:0]   rec_rr2    [1:MAX];
  logic [31:0]  rec_imm    [1:MAX];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Starts at posedge+1 with the DUT in FETCH; returns at posedge+1 after the
  // cycle carrying pc_write. The data memory answers after ready_delay waits.
  task automatic run_instr(input logic [31:0] instr, input int ready_delay, input logic zero);
    int mem_cnt;
    bit done;
    mem_cnt  = 0;
    done     = 1'b0;
    n_cycles = 0;
    rec_pcw = '0; rec_regw = '0; rec_mrd = '0; rec_mwr = '0;
    rec_req = '0; rec_imm_sel = '0; rec_ill = '0;
    for (int i = 1; i <= MAX; i++) begin
      rec_pc_src[i] = '0; rec_alu_op[i] = '0; rec_wr[i] = '0;
      rec_rr1[i] = '0; rec_rr2[i] = '0; rec_imm[i] = '0;
    end
    bus.instruction = instr;
    bus.instr_valid = 1'b1;
    bus.alu_zero    = zero;
    bus.mem_ready   = 1'b0;
    while (!done && n_cycles < MAX) begin
      n_cycles++;
      #1;
      bus.mem_ready = 1'b0;
      if (bus.mem_read || bus.mem_write) begin
        if (mem_cnt == ready_delay) bus.mem_ready = 1'b1;
        mem_cnt++;
      end
      @(negedge clk);
      rec_pcw[n_cycles]     = bus.pc_write;
      rec_regw[n_cycles]    = bus.signal_reg_write;
      rec_mrd[n_cycles]     = bus.mem_read;
      rec_mwr[n_cycles]     = bus.mem_write;
      rec_req[n_cycles]     = bus.instr_req;
      rec_imm_sel[n_cycles] = bus.alu_src_imm;
      rec_ill[n_cycles]     = bus.illegal;
      rec_pc_src[n_cycles]  = bus.pc_src;
      rec_alu_op[n_cycles]  = bus.alu_op;
      rec_wr[n_cycles]      = bus.write_reg;
      rec_rr1[n_cycles]     = bus.read_reg_1;
      rec_rr2[n_cycles]     = bus.read_reg_2;
      rec_imm[n_cycles]     = bus.imm_ext;
      done = (bus.pc_write === 1'b1);
      tick();
    end
    bus.instr_valid = 1'b0;
    bus.mem_ready   = 1'b0;
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL timeout %h: no pc_write within %0d cycles", instr, MAX);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vectors++; if (bus.instr_req !== 1'b1) begin miscompares++; $display("FAIL reset instr_req: got %b want 1", bus.instr_req); end
    vectors++; if ({bus.pc_write, bus.signal_reg_write, bus.mem_read, bus.mem_write} !== 4'b0000) begin miscompares++; $display("FAIL reset strobes: got %b want 0000", {bus.pc_write, bus.signal_reg_write, bus.mem_read, bus.mem_write}); end
    vectors++; if (bus.alu_op !== 3'b000 || bus.pc_src !== 2'b00) begin miscompares++; $display("FAIL reset alu_op/pc_src: got %b/%b want 000/00", bus.alu_op, bus.pc_src); end
    vectors++; if ({bus.read_reg_1, bus.read_reg_2, bus.write_reg} !== 9'd0) begin miscompares++; $display("FAIL reset addresses: got %b want 0", {bus.read_reg_1, bus.read_reg_2, bus.write_reg}); end
    vectors++; if (bus.imm_ext !== 32'h0 || bus.illegal !== 1'b0) begin miscompares++; $display("FAIL reset imm/illegal: got %h/%b want 0/0", bus.imm_ext, bus.illegal); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_add;
    run_instr(32'h00221820, 0, 1'b0);
    vectors++; if (n_cycles != 4) begin miscompares++; $display("FAIL add cycles: got %0d want 4", n_cycles); end
    vectors++; if (rec_req !== 16'h0001) begin miscompares++; $display("FAIL add instr_req: got %h want 0001", rec_req); end
    vectors++; if (rec_rr1[2] !== 3'b001 || rec_rr2[2] !== 3'b010) begin miscompares++; $display("FAIL add read regs: got %b/%b want 001/010", rec_rr1[2], rec_rr2[2]); end
    vectors++; if (rec_alu_op[3] !== 3'b000 || rec_imm_sel[3] !== 1'b0) begin miscompares++; $display("FAIL add alu: got %b/%b want 000/0", rec_alu_op[3], rec_imm_sel[3]); end
    vectors++; if (rec_wr[4] !== 3'b011) begin miscompares++; $display("FAIL add write_reg: got %b want 011", rec_wr[4]); end
    vectors++; if (rec_regw !== 16'h0008 || rec_pcw !== 16'h0008) begin miscompares++; $display("FAIL add pulses: reg_write %h pc_write %h want 0008/0008", rec_regw, rec_pcw); end
  endtask

  task automatic test_rtype_alu;
    logic [31:0] instrs [4];
    logic [2:0]  ops    [4];
    instrs = '{32'h00221822, 32'h00221824, 32'h00221825, 32'h0022182A};
    ops    = '{3'b001, 3'b010, 3'b011, 3'b100};
    for (int i = 0; i < 4; i++) begin
      run_instr(instrs[i], 0, 1'b0);
      vectors++; if (rec_alu_op[3] !== ops[i]) begin miscompares++; $display("FAIL rtype alu_op %h: got %b want %b", instrs[i], rec_alu_op[3], ops[i]); end
    end
    run_instr(32'h00221821, 0, 1'b0);
    vectors++; if (rec_pcw !== 16'h0002 || rec_regw !== 16'h0000) begin miscompares++; $display("FAIL bad funct: pc_write %h reg_write %h want 0002/0000", rec_pcw, rec_regw); end
    @(negedge clk);
    vectors++; if (bus.illegal !== 1'b1) begin miscompares++; $display("FAIL bad funct illegal: got %b want 1", bus.illegal); end
    tick();
  endtask

  task automatic test_lw_sw;
    run_instr(32'h8C240008, 2, 1'b0);
    vectors++; if (n_cycles != 7) begin miscompares++; $display("FAIL lw cycles: got %0d want 7", n_cycles); end
    vectors++; if (rec_imm[2] !== 32'h8 || rec_imm_sel[3] !== 1'b1) begin miscompares++; $display("FAIL lw imm: got %h/%b want 00000008/1", rec_imm[2], rec_imm_sel[3]); end
    vectors++; if (rec_mrd !== 16'h0038 || rec_mwr !== 16'h0000) begin miscompares++; $display("FAIL lw mem strobes: read %h write %h want 0038/0000", rec_mrd, rec_mwr); end
    vectors++; if (rec_regw !== 16'h0040 || rec_wr[7] !== 3'b100) begin miscompares++; $display("FAIL lw writeback: reg_write %h reg %b want 0040/100", rec_regw, rec_wr[7]); end
    vectors++; if (rec_pcw !== 16'h0040) begin miscompares++; $display("FAIL lw pc_write: got %h want 0040", rec_pcw); end
    run_instr(32'hAC240008, 2, 1'b0);
    vectors++; if (rec_mwr !== 16'h0038 || rec_mrd !== 16'h0000) begin miscompares++; $display("FAIL sw mem strobes: write %h read %h want 0038/0000", rec_mwr, rec_mrd); end
    vectors++; if (rec_pcw !== 16'h0020 || rec_pc_src[6] !== 2'b00) begin miscompares++; $display("FAIL sw pc_write: got %h src %b want 0020/00", rec_pcw, rec_pc_src[6]); end
    vectors++; if (rec_regw !== 16'h0000) begin miscompares++; $display("FAIL sw reg_write: got %h want 0000", rec_regw); end
  endtask

  task automatic test_beq;
    run_instr(32'h10220003, 0, 1'b1);
    vectors++; if (rec_pcw !== 16'h0004 || rec_pc_src[3] !== 2'b01) begin miscompares++; $display("FAIL beq taken: pc_write %h src %b want 0004/01", rec_pcw, rec_pc_src[3]); end
    vectors++; if (rec_alu_op[3] !== 3'b001 || rec_regw !== 16'h0000) begin miscompares++; $display("FAIL beq alu/reg: got %b/%h want 001/0000", rec_alu_op[3], rec_regw); end
    run_instr(32'h10220003, 0, 1'b0);
    vectors++; if (rec_pcw !== 16'h0004 || rec_pc_src[3] !== 2'b00) begin miscompares++; $display("FAIL beq not taken: pc_write %h src %b want 0004/00", rec_pcw, rec_pc_src[3]); end
  endtask

  task automatic test_addi;
    run_instr(32'h2003FFFF, 0, 1'b0);
    vectors++; if (rec_imm[2] !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL addi imm_ext: got %h want ffffffff", rec_imm[2]); end
    vectors++; if (rec_imm_sel[3] !== 1'b1 || rec_alu_op[3] !== 3'b000) begin miscompares++; $display("FAIL addi alu: got %b/%b want 1/000", rec_imm_sel[3], rec_alu_op[3]); end
    vectors++; if (rec_wr[4] !== 3'b011 || rec_regw !== 16'h0008) begin miscompares++; $display("FAIL addi writeback: reg %b reg_write %h want 011/0008", rec_wr[4], rec_regw); end
    run_instr(32'h2000FFFF, 0, 1'b0);
    vectors++; if (rec_regw !== 16'h0000 || rec_pcw !== 16'h0008) begin miscompares++; $display("FAIL addi rt0: reg_write %h pc_write %h want 0000/0008", rec_regw, rec_pcw); end
  endtask

  task automatic test_jump_illegal;
    run_instr(32'h08000010, 0, 1'b0);
    vectors++; if (n_cycles != 2 || rec_pc_src[2] !== 2'b10) begin miscompares++; $display("FAIL j: cycles %0d src %b want 2/10", n_cycles, rec_pc_src[2]); end
    vectors++; if (rec_pcw !== 16'h0002 || rec_regw !== 16'h0000) begin miscompares++; $display("FAIL j pulses: pc_write %h reg_write %h want 0002/0000", rec_pcw, rec_regw); end
    run_instr(32'hFC000000, 0, 1'b0);
    vectors++; if (rec_pcw !== 16'h0002 || rec_pc_src[2] !== 2'b00) begin miscompares++; $display("FAIL illegal pc: pc_write %h src %b want 0002/00", rec_pcw, rec_pc_src[2]); end
    vectors++; if (rec_regw !== 16'h0000) begin miscompares++; $display("FAIL illegal reg_write: got %h want 0000", rec_regw); end
    @(negedge clk);
    vectors++; if (bus.illegal !== 1'b1) begin miscompares++; $display("FAIL illegal flag: got %b want 1", bus.illegal); end
    tick();
    run_instr(32'h00221820, 0, 1'b0);
    vectors++; if (rec_ill[1] !== 1'b1 || rec_ill[2] !== 1'b0) begin miscompares++; $display("FAIL illegal clear: fetch %b decode %b want 1/0", rec_ill[1], rec_ill[2]); end
  endtask

  task automatic test_reset_mid;
    // Reset while a lw waits in MEM
    bus.instruction = 32'h8C240008;
    bus.instr_valid = 1'b1;
    bus.mem_ready   = 1'b0;
    tick();
    bus.instr_valid = 1'b0;
    tick(); tick();
    @(negedge clk);
    vectors++; if (bus.mem_read !== 1'b1) begin miscompares++; $display("FAIL mid lw mem_read: got %b want 1", bus.mem_read); end
    tick();
    reset = 1'b1;
    @(negedge clk);
    vectors++; if (bus.pc_write !== 1'b0 || bus.mem_read !== 1'b0) begin miscompares++; $display("FAIL reset in mem: pc_write %b mem_read %b want 0/0", bus.pc_write, bus.mem_read); end
    tick();
    reset = 1'b0;
    @(negedge clk);
    vectors++; if (bus.instr_req !== 1'b1 || bus.mem_read !== 1'b0 || bus.pc_write !== 1'b0) begin miscompares++; $display("FAIL after reset: req %b mem_read %b pc_write %b want 1/0/0", bus.instr_req, bus.mem_read, bus.pc_write); end
    vectors++; if (bus.imm_ext !== 32'h0 || bus.read_reg_1 !== 3'b000) begin miscompares++; $display("FAIL IR cleared: imm %h rs %b want 0/000", bus.imm_ext, bus.read_reg_1); end
    tick();
    // Reset while an add sits in WRITEBACK
    bus.instruction = 32'h00221820;
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    tick(); tick();
    reset = 1'b1;
    @(negedge clk);
    vectors++; if (bus.signal_reg_write !== 1'b0 || bus.pc_write !== 1'b0) begin miscompares++; $display("FAIL reset in writeback: reg_write %b pc_write %b want 0/0", bus.signal_reg_write, bus.pc_write); end
    tick();
    reset = 1'b0;
    @(negedge clk);
    vectors++; if (bus.instr_req !== 1'b1 || bus.write_reg !== 3'b000) begin miscompares++; $display("FAIL after writeback reset: req %b rd %b want 1/000", bus.instr_req, bus.write_reg); end
    tick();
  endtask

  initial begin
    reset           = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instruction = '0;
    bus.mem_ready   = 1'b0;
    bus.alu_zero    = 1'b0;
    test_reset();
    test_add();
    test_rtype_alu();
    test_lw_sw();
    test_beq();
    test_addi();
    test_jump_illegal();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
